// File: rtl/sprite_pixel_fetch_if.sv
// Bundle of the pixel, ROM and sequencer signals of the sprite fetch engine.
// The slave modport is the engine's view; the master modport is its environment.
interface sprite_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IDX_W  = 4
);
  // Frame and pixel stream
  logic              frame_tick;
  logic              pix_valid;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic [1:0]        dir;
  logic              moving;
  logic              attack;

  // Sprite ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;

  // Sequencer state seen by the ROM mux
  logic [1:0]        dir_q;
  logic              walk_phase;
  logic              attacking;
  logic [1:0]        atk_phase;

  // Aligned pixel result
  logic              pix_out_valid;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_opaque;

  modport slave (
    input  frame_tick, pix_valid, draw_x, draw_y, sprite_x, sprite_y, dir, moving, attack,
    input  rom_q,
    output rom_addr, dir_q, walk_phase, attacking, atk_phase,
    output pix_out_valid, pix_idx, pix_opaque
  );

  modport master (
    output frame_tick, pix_valid, draw_x, draw_y, sprite_x, sprite_y, dir, moving, attack,
    output rom_q,
    input  rom_addr, dir_q, walk_phase, attacking, atk_phase,
    input  pix_out_valid, pix_idx, pix_opaque
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite fetch engine: coordinate-to-ROM-address conversion with a
// 3-cycle aligned pixel pipeline, plus the walk and attack frame sequencers.
module sprite_pixel_fetch #(
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned SPRITE_H        = 32,
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned WALK_DIV        = 8,
  parameter int unsigned ATK_DIV         = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sprite_pixel_fetch_if.slave  bus_io
);

  localparam int unsigned XW        = $clog2(SPRITE_W);
  localparam int unsigned YW        = $clog2(SPRITE_H);
  localparam int unsigned WalkCntW  = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
  localparam int unsigned AtkCntW   = (ATK_DIV > 1) ? $clog2(ATK_DIV) : 1;

  localparam logic [9:0]          SpriteWL = 10'(SPRITE_W);
  localparam logic [9:0]          SpriteHL = 10'(SPRITE_H);
  localparam logic [WalkCntW-1:0] WalkMax  = WalkCntW'(WALK_DIV - 1);
  localparam logic [AtkCntW-1:0]  AtkMax   = AtkCntW'(ATK_DIV - 1);
  localparam logic [IDX_W-1:0]    TranspL  = IDX_W'(TRANSPARENT_IDX);

  typedef enum logic [1:0] {
    StIdle,
    StAttack,
    StRecover
  } state_e;

  // Sequencer state
  state_e              state_q, state_d;
  logic [9:0]          sx_q, sx_d;
  logic [9:0]          sy_q, sy_d;
  logic [1:0]          dir_q, dir_d;
  logic [WalkCntW-1:0] walk_cnt_q, walk_cnt_d;
  logic                walk_phase_q, walk_phase_d;
  logic [AtkCntW-1:0]  atk_cnt_q, atk_cnt_d;
  logic [1:0]          atk_phase_q, atk_phase_d;

  // Pixel pipeline state
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                v1_q, v2_q, b1_q, b2_q;
  logic                pix_out_valid_q;
  logic                pix_opaque_q, pix_opaque_d;
  logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;

  logic [9:0]          dx, dy;
  logic                in_box;

  // Box test against the latched position; negative offsets wrap and fail.
  always_comb begin
    dx         = bus_io.draw_x - sx_q;
    dy         = bus_io.draw_y - sy_q;
    in_box     = bus_io.pix_valid & (dx < SpriteWL) & (dy < SpriteHL);
    rom_addr_d = '0;
    if (in_box) begin
      rom_addr_d = ADDR_W'({dy[YW-1:0], dx[XW-1:0]});
    end
  end

  // Output stage: rom_q lines up with the box flag delayed by two cycles.
  always_comb begin
    pix_opaque_d = b2_q & (bus_io.rom_q != TranspL);
    pix_idx_d    = pix_opaque_d ? bus_io.rom_q : '0;
  end

  // Pixel pipeline registers: address, two alignment stages, output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rom_addr_q      <= '0;
      v1_q            <= 1'b0;
      v2_q            <= 1'b0;
      b1_q            <= 1'b0;
      b2_q            <= 1'b0;
      pix_out_valid_q <= 1'b0;
      pix_opaque_q    <= 1'b0;
      pix_idx_q       <= '0;
    end else begin
      rom_addr_q      <= rom_addr_d;
      v1_q            <= bus_io.pix_valid;
      b1_q            <= in_box;
      v2_q            <= v1_q;
      b2_q            <= b1_q;
      pix_out_valid_q <= v2_q;
      pix_opaque_q    <= pix_opaque_d;
      pix_idx_q       <= pix_idx_d;
    end
  end

  // Frame latch, walk counter and attack FSM; everything moves only on frame_tick.
  always_comb begin
    state_d      = state_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    dir_d        = dir_q;
    walk_cnt_d   = walk_cnt_q;
    walk_phase_d = walk_phase_q;
    atk_cnt_d    = atk_cnt_q;
    atk_phase_d  = atk_phase_q;

    if (bus_io.frame_tick) begin
      sx_d = bus_io.sprite_x;
      sy_d = bus_io.sprite_y;
      unique case (state_q)
        StIdle: begin
          dir_d = bus_io.dir;
          if (bus_io.attack) begin
            // Attack takes priority over walking; walk state is left frozen.
            state_d     = StAttack;
            atk_cnt_d   = '0;
            atk_phase_d = 2'd0;
          end else if (bus_io.moving) begin
            if (walk_cnt_q == WalkMax) begin
              walk_cnt_d   = '0;
              walk_phase_d = ~walk_phase_q;
            end else begin
              walk_cnt_d = walk_cnt_q + 1'b1;
            end
          end else begin
            walk_cnt_d   = '0;
            walk_phase_d = 1'b0;
          end
        end
        StAttack: begin
          if (atk_cnt_q == AtkMax) begin
            atk_cnt_d = '0;
            if (atk_phase_q == 2'd3) begin
              state_d     = StRecover;
              atk_phase_d = 2'd0;
            end else begin
              atk_phase_d = atk_phase_q + 2'd1;
            end
          end else begin
            atk_cnt_d = atk_cnt_q + 1'b1;
          end
        end
        StRecover: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sx_q         <= '0;
      sy_q         <= '0;
      dir_q        <= 2'd1;
      walk_cnt_q   <= '0;
      walk_phase_q <= 1'b0;
      atk_cnt_q    <= '0;
      atk_phase_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dir_q        <= dir_d;
      walk_cnt_q   <= walk_cnt_d;
      walk_phase_q <= walk_phase_d;
      atk_cnt_q    <= atk_cnt_d;
      atk_phase_q  <= atk_phase_d;
    end
  end

  assign bus_io.rom_addr      = rom_addr_q;
  assign bus_io.dir_q         = dir_q;
  assign bus_io.walk_phase    = walk_phase_q;
  assign bus_io.attacking     = (state_q == StAttack);
  assign bus_io.atk_phase     = atk_phase_q;
  assign bus_io.pix_out_valid = pix_out_valid_q;
  assign bus_io.pix_idx       = pix_idx_q;
  assign bus_io.pix_opaque    = pix_opaque_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench for sprite_pixel_fetch with a behavioural reference model.
module tb_sprite_pixel_fetch;

  localparam int SW   = 32;
  localparam int SH   = 32;
  localparam int WDIV = 8;
  localparam int ADIV = 4;

  logic clk;
  logic rst_n;

  sprite_pixel_fetch_if #(.ADDR_W(10), .IDX_W(4)) bus ();

  sprite_pixel_fetch #(
    .SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(10), .IDX_W(4), .TRANSPARENT_IDX(0),
    .WALK_DIV(WDIV), .ATK_DIV(ADIV)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read sprite ROM
  logic [3:0] rom_mem [1024];
  always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

  int n_vec;
  int n_err;

  // Reference model: position, facing, walk ticks, attack frames elapsed.
  int   m_sx, m_sy, m_dir;
  int   m_mode;       // 0 idle, 1 attack, 2 recover
  int   m_walk_cnt, m_walk_ph;
  int   m_atk_ticks;  // frame_ticks spent in attack so far
  int   e_addr;
  logic e_v [3];
  logic e_op [3];
  int   e_idx [3];

  function automatic logic [5:0] exp_seq();
    int ph;
    ph = (m_mode == 1) ? m_atk_ticks / ADIV : 0;
    return {2'(m_dir), 1'(m_walk_ph), m_mode == 1, 2'(ph)};
  endfunction

  function automatic logic [5:0] exp_pix();
    return {e_v[2], e_op[2], 4'(e_idx[2])};
  endfunction

  task automatic reset_model();
    m_sx = 0; m_sy = 0; m_dir = 1; m_mode = 0;
    m_walk_cnt = 0; m_walk_ph = 0; m_atk_ticks = 0; e_addr = 0;
    for (int i = 0; i < 3; i++) begin
      e_v[i] = 1'b0; e_op[i] = 1'b0; e_idx[i] = 0;
    end
  endtask

  task automatic model_tick();
    if (m_mode == 0) begin
      m_dir = int'(bus.dir);
      if (bus.attack) begin
        m_mode = 1; m_atk_ticks = 0;
      end else if (bus.moving) begin
        m_walk_cnt++;
        if (m_walk_cnt == WDIV) begin
          m_walk_cnt = 0; m_walk_ph = 1 - m_walk_ph;
        end
      end else begin
        m_walk_cnt = 0; m_walk_ph = 0;
      end
    end else if (m_mode == 1) begin
      m_atk_ticks++;
      if (m_atk_ticks == 4 * ADIV) m_mode = 2;
    end else begin
      m_mode = 0;
    end
    m_sx = int'(bus.sprite_x);
    m_sy = int'(bus.sprite_y);
  endtask

  // One clock of stimulus; the model sees the pixel before the frame latch.
  task automatic cycle(input logic ft, input logic pv, input int x, input int y);
    int   dx, dy, a;
    logic inb;
    bus.frame_tick = ft;
    bus.pix_valid  = pv;
    bus.draw_x     = 10'(x);
    bus.draw_y     = 10'(y);
    dx  = (x - m_sx) & 1023;
    dy  = (y - m_sy) & 1023;
    inb = pv && (dx < SW) && (dy < SH);
    a   = inb ? dy * SW + dx : 0;
    e_addr = a;
    for (int i = 2; i > 0; i--) begin
      e_v[i] = e_v[i-1]; e_op[i] = e_op[i-1]; e_idx[i] = e_idx[i-1];
    end
    e_v[0]   = pv;
    e_op[0]  = inb && (rom_mem[a] != 4'd0);
    e_idx[0] = e_op[0] ? int'(rom_mem[a]) : 0;
    if (ft) model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.frame_tick = 1'b0; bus.pix_valid = 1'b0; bus.draw_x = '0; bus.draw_y = '0;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.dir = 2'd1; bus.moving = 1'b0;
    bus.attack = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (bus.rom_addr !== 10'd0) begin
      n_err++; $display("FAIL reset rom_addr got %0d want 0", bus.rom_addr);
    end
    n_vec++;
    if ({bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== 6'd0) begin
      n_err++; $display("FAIL reset pix got %b want 000000",
                        {bus.pix_out_valid, bus.pix_opaque, bus.pix_idx});
    end
    n_vec++;
    if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== 6'b01_0_0_00) begin
      n_err++; $display("FAIL reset seq got %b want 010000",
                        {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase});
    end
  endtask

  task automatic test_box_edges();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'(i) | 4'd1;
    bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
    cycle(1'b1, 1'b0, 0, 0);
    for (int j = 0; j < 37; j++) begin
      if (j < 34) cycle(1'b0, 1'b1, 99 + j, 50);
      else        cycle(1'b0, 1'b0, 0, 0);
      n_vec++;
      if (bus.rom_addr !== 10'(e_addr)) begin
        n_err++; $display("FAIL box rom_addr step %0d got %0d want %0d", j, bus.rom_addr, e_addr);
      end
      n_vec++;
      if ({bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== exp_pix()) begin
        n_err++; $display("FAIL box pix step %0d got %b want %b", j,
                          {bus.pix_out_valid, bus.pix_opaque, bus.pix_idx}, exp_pix());
      end
    end
  endtask

  task automatic test_wrap_transparency();
    int xs [8] = '{1, 5, 10, 36, 5, 36, 4, 20};
    int ys [8] = '{3, 5, 20, 5, 37, 36, 4, 4};
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd0;
    bus.sprite_x = 10'd5; bus.sprite_y = 10'd5;
    cycle(1'b1, 1'b0, 0, 0);
    for (int j = 0; j < 11; j++) begin
      if (j < 8) cycle(1'b0, 1'b1, xs[j], ys[j]);
      else       cycle(1'b0, 1'b0, 0, 0);
      n_vec++;
      if (bus.rom_addr !== 10'(e_addr)) begin
        n_err++; $display("FAIL wrap rom_addr step %0d got %0d want %0d", j, bus.rom_addr, e_addr);
      end
      n_vec++;
      if ({bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== exp_pix()) begin
        n_err++; $display("FAIL transp pix step %0d got %b want %b", j,
                          {bus.pix_out_valid, bus.pix_opaque, bus.pix_idx}, exp_pix());
      end
    end
  endtask

  task automatic test_same_cycle_latch();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'($urandom_range(1, 15));
    bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
    cycle(1'b1, 1'b0, 0, 0);
    bus.sprite_x = 10'd200;
    for (int j = 0; j < 6; j++) begin
      case (j)
        0:       cycle(1'b1, 1'b1, 110, 60);
        1:       cycle(1'b0, 1'b1, 110, 60);
        2:       cycle(1'b0, 1'b1, 210, 60);
        default: cycle(1'b0, 1'b0, 0, 0);
      endcase
      n_vec++;
      if (bus.rom_addr !== 10'(e_addr)) begin
        n_err++; $display("FAIL latch rom_addr step %0d got %0d want %0d", j, bus.rom_addr, e_addr);
      end
      n_vec++;
      if ({bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== exp_pix()) begin
        n_err++; $display("FAIL latch pix step %0d got %b want %b", j,
                          {bus.pix_out_valid, bus.pix_opaque, bus.pix_idx}, exp_pix());
      end
    end
  endtask

  task automatic test_walk();
    bus.moving = 1'b1; bus.attack = 1'b0; bus.dir = 2'd2;
    for (int t = 0; t < 18; t++) begin
      if (t == 17) bus.moving = 1'b0;
      cycle(1'b1, 1'b0, 0, 0);
      n_vec++;
      if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== exp_seq()) begin
        n_err++; $display("FAIL walk tick %0d got %b want %b", t,
                          {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase}, exp_seq());
      end
      cycle(1'b0, 1'b0, 0, 0);
      n_vec++;
      if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== exp_seq()) begin
        n_err++; $display("FAIL walk hold %0d got %b want %b", t,
                          {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase}, exp_seq());
      end
    end
  endtask

  task automatic test_attack();
    bus.moving = 1'b1; bus.attack = 1'b1; bus.dir = 2'd3;
    for (int t = 0; t < 21; t++) begin
      if (t == 1) bus.attack = 1'b0;
      if (t > 0) bus.dir = 2'($urandom_range(0, 3));
      cycle(1'b1, 1'b0, 0, 0);
      n_vec++;
      if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== exp_seq()) begin
        n_err++; $display("FAIL attack tick %0d got %b want %b", t,
                          {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase}, exp_seq());
      end
    end
    bus.moving = 1'b0;
  endtask

  task automatic test_reset_mid_attack();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd7;
    bus.sprite_x = 10'd0; bus.sprite_y = 10'd0; bus.attack = 1'b1;
    cycle(1'b1, 1'b0, 0, 0);
    bus.attack = 1'b0;
    for (int t = 0; t < 9; t++) cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 3, 2);
    cycle(1'b0, 1'b1, 4, 2);
    n_vec++;
    if ({bus.attacking, bus.atk_phase, bus.rom_addr} !== {1'b1, 2'd2, 10'(e_addr)}) begin
      n_err++; $display("FAIL pre-reset got %b want %b", {bus.attacking, bus.atk_phase, bus.rom_addr},
                        {1'b1, 2'd2, 10'(e_addr)});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rom_addr, bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== 16'd0) begin
      n_err++; $display("FAIL async reset pix got %b want 0",
                        {bus.rom_addr, bus.pix_out_valid, bus.pix_opaque, bus.pix_idx});
    end
    n_vec++;
    if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== 6'b01_0_0_00) begin
      n_err++; $display("FAIL async reset seq got %b want 010000",
                        {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase});
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    cycle(1'b1, 1'b0, 0, 0);
    n_vec++;
    if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== exp_seq()) begin
      n_err++; $display("FAIL post-reset tick got %b want %b",
                        {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase}, exp_seq());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    for (int j = 0; j < 1500; j++) begin
      logic ft, pv;
      int   x, y;
      ft = ($urandom_range(0, 5) == 0);
      pv = ($urandom_range(0, 3) != 0);
      x  = (m_sx + int'($urandom_range(0, 40)) - 4) & 1023;
      y  = (m_sy + int'($urandom_range(0, 40)) - 4) & 1023;
      if (j >= 1497) pv = 1'b0;
      bus.sprite_x = 10'($urandom_range(0, 1023));
      bus.sprite_y = 10'($urandom_range(0, 1023));
      bus.dir      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.moving = ~bus.moving;
      bus.attack = ($urandom_range(0, 7) == 0);
      cycle(ft, pv, x, y);
      n_vec++;
      if (bus.rom_addr !== 10'(e_addr)) begin
        n_err++; $display("FAIL rand rom_addr cyc %0d got %0d want %0d", j, bus.rom_addr, e_addr);
      end
      n_vec++;
      if ({bus.pix_out_valid, bus.pix_opaque, bus.pix_idx} !== exp_pix()) begin
        n_err++; $display("FAIL rand pix cyc %0d got %b want %b", j,
                          {bus.pix_out_valid, bus.pix_opaque, bus.pix_idx}, exp_pix());
      end
      n_vec++;
      if ({bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase} !== exp_seq()) begin
        n_err++; $display("FAIL rand seq cyc %0d got %b want %b", j,
                          {bus.dir_q, bus.walk_phase, bus.attacking, bus.atk_phase}, exp_seq());
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.rom_q = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd0;
    idle_inputs();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_box_edges();
    test_wrap_transparency();
    test_same_cycle_latch();
    test_walk();
    test_attack();
    test_reset_mid_attack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
